// File: rtl/if_stage_mo_if.sv
// Fetch-stage bundle: decode handshake, branch/flush
// inputs and the SRAM-like instruction port.
interface if_stage_mo_if;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_flush_pipe;
  logic [31:0] ws_to_fs_bus;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin,
    input  br_bus,
    input  fs_flush_pipe,
    input  ws_to_fs_bus,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_req,
    output inst_sram_wr,
    output inst_sram_size,
    output inst_sram_wstrb,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    output fs_flush_pipe,
    output ws_to_fs_bus,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_req,
    input  inst_sram_wr,
    input  inst_sram_size,
    input  inst_sram_wstrb,
    input  inst_sram_addr,
    input  inst_sram_wdata
  );
endinterface

// File: rtl/if_stage_mo.sv
// Multi-outstanding fetch stage with PC queue and IBUF.
// Optional IF_ADEF_CHECK_EN: misaligned-PC ADEF entries.
module if_stage_mo #(
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  parameter int          OUTSTANDING = 2,
  parameter int          IBUF_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  if_stage_mo_if.master bus
);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int QW = (OUTSTANDING > 1) ?
                      $clog2(OUTSTANDING) : 1;
  localparam int BW = (IBUF_DEPTH > 1) ?
                      $clog2(IBUF_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_S = (CW+1)'(IBUF_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
  localparam logic [CW-1:0] OUT_C   = CW'(OUTSTANDING);
  localparam logic [QW-1:0] PQ_LAST = QW'(OUTSTANDING - 1);
  localparam logic [BW-1:0] IB_LAST = BW'(IBUF_DEPTH - 1);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_stale;
  logic [CW-1:0] r_ib_cnt;
  logic [31:0]   r_pcq [OUTSTANDING];
  logic [QW-1:0] r_pq_wr;
  logic [QW-1:0] r_pq_rd;
  logic [64:0]   r_ibuf [IBUF_DEPTH];
  logic [BW-1:0] r_ib_wr;
  logic [BW-1:0] r_ib_rd;

  logic          w_br_stall;
  logic          w_br_redir;
  logic [31:0]   w_br_target;
  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_full;
  logic          w_credit;
  logic          w_req;
  logic          w_acc;
  logic          w_dok;
  logic          w_deliver;
  logic          w_push;
  logic          w_pop;
  logic [64:0]   w_push_data;
  logic [CW-1:0] w_inflight_nx;
  logic          w_adef;
  logic          w_adef_hold;
  logic          w_adef_push;

  assign w_br_stall  = bus.br_bus[33];
  assign w_br_redir  = bus.br_bus[32];
  assign w_br_target = bus.br_bus[31:0];
  assign w_redirect  = bus.fs_flush_pipe | w_br_redir;
  assign w_target    = bus.fs_flush_pipe ?
                       bus.ws_to_fs_bus : w_br_target;

  assign w_full   = (r_ib_cnt == DEPTH_C);
  assign w_credit = ({1'b0, r_ib_cnt} +
                     {1'b0, r_inflight}) < DEPTH_S;
  assign w_req    = !reset && !w_redirect &&
                    !w_br_stall && !w_adef_hold &&
                    !w_adef && (r_inflight < OUT_C) &&
                    w_credit;
  assign w_acc     = w_req & bus.inst_sram_addr_ok;
  assign w_dok     = bus.inst_sram_data_ok &
                     (r_inflight != '0);
  assign w_deliver = w_dok & (r_stale == '0);
  assign w_push    = (w_deliver | w_adef_push) &
                     !w_redirect;
  assign w_pop     = bus.fs_to_ds_valid & bus.ds_allowin;
  assign w_inflight_nx = r_inflight + CW'(w_acc) -
                         CW'(w_dok);
  assign w_push_data = w_adef_push ?
    {1'b1, 32'h0, r_fetch_pc} :
    {1'b0, bus.inst_sram_rdata, r_pcq[r_pq_rd]};

`ifdef IF_ADEF_CHECK_EN
  logic r_adef_hold;
  assign w_adef      = |r_fetch_pc[1:0];
  assign w_adef_hold = r_adef_hold;
  assign w_adef_push = w_adef && !r_adef_hold &&
                       (r_inflight == '0) &&
                       (r_stale == '0) && !w_full &&
                       !w_redirect && !reset;
  assign bus.inst_sram_addr = r_fetch_pc;

  // one ADEF entry per hold; a redirect re-arms it
  always_ff @(posedge clk) begin
    if (reset || w_redirect) r_adef_hold <= 1'b0;
    else if (w_adef_push)    r_adef_hold <= 1'b1;
  end
`else
  assign w_adef      = 1'b0;
  assign w_adef_hold = 1'b0;
  assign w_adef_push = 1'b0;
  assign bus.inst_sram_addr = {r_fetch_pc[31:2], 2'b00};
`endif

  assign bus.inst_sram_req   = w_req;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = 2'h2;
  assign bus.inst_sram_wstrb = 4'h0;
  assign bus.inst_sram_wdata = 32'h0;
  assign bus.fs_to_ds_valid  = !reset && !w_redirect &&
                               (r_ib_cnt != '0);
  assign bus.fs_to_ds_bus    = r_ibuf[r_ib_rd];

  // fetch PC: redirect target wins, else step on accept
  always_ff @(posedge clk) begin
    if (reset)           r_fetch_pc <= RESET_PC;
    else if (w_redirect) r_fetch_pc <= w_target;
    else if (w_acc)      r_fetch_pc <= r_fetch_pc + 32'd4;
  end

  // outstanding count and old-path responses to drop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_stale    <= '0;
    end else begin
      r_inflight <= w_inflight_nx;
      if (w_redirect)
        r_stale <= w_inflight_nx;
      else if (w_dok && (r_stale != '0))
        r_stale <= r_stale - 1'b1;
    end
  end

  // PC queue pointers: survive redirects, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pq_wr <= '0;
      r_pq_rd <= '0;
    end else begin
      if (w_acc)
        r_pq_wr <= (r_pq_wr == PQ_LAST) ?
                   '0 : r_pq_wr + 1'b1;
      if (w_dok)
        r_pq_rd <= (r_pq_rd == PQ_LAST) ?
                   '0 : r_pq_rd + 1'b1;
    end
  end

  // PC queue storage: tag each accepted request
  always_ff @(posedge clk) begin
    if (w_acc) r_pcq[r_pq_wr] <= r_fetch_pc;
  end

  // IBUF pointers/count, squashed by any redirect
  always_ff @(posedge clk) begin
    if (reset || w_redirect) begin
      r_ib_wr  <= '0;
      r_ib_rd  <= '0;
      r_ib_cnt <= '0;
    end else begin
      if (w_push)
        r_ib_wr <= (r_ib_wr == IB_LAST) ?
                   '0 : r_ib_wr + 1'b1;
      if (w_pop)
        r_ib_rd <= (r_ib_rd == IB_LAST) ?
                   '0 : r_ib_rd + 1'b1;
      r_ib_cnt <= r_ib_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // IBUF storage
  always_ff @(posedge clk) begin
    if (w_push) r_ibuf[r_ib_wr] <= w_push_data;
  end

  a_ibuf_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(w_push && !w_pop && w_full));
endmodule

// File: tb/tb_if_stage_mo.sv
// Scoreboard bench for if_stage_mo: SRAM model,
// directed redirect/flush/backpressure scenarios.
module tb_if_stage_mo;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_stage_mo_if bus ();

  if_stage_mo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q [$];
  logic [31:0] rq [$];
  int grant_lim = 0;
  int acc_cnt = 0;
  int max_q = 0;
  logic resp_en = 1'b0;

  assign bus.inst_sram_addr_ok = (acc_cnt < grant_lim);

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16]};
  endfunction

  task automatic chk(input string nm,
                     input logic [64:0] act,
                     input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({1'b0, mem(pc), pc});
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rq.size() != 0 ||
            acc_cnt != grant_lim) && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0",
               nm, exp_q.size());
    end
  endtask

  // SRAM model: samples accepts mid-cycle, answers next cycle
  logic        acc_s;
  logic [31:0] acc_a;
  initial begin
    acc_s = 1'b0;
    acc_a = '0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = '0;
    forever begin
      @(negedge clk);
      acc_s = bus.inst_sram_req & bus.inst_sram_addr_ok;
      acc_a = bus.inst_sram_addr;
      @(posedge clk);
      #1;
      if (reset) begin
        rq.delete();
        bus.inst_sram_data_ok = 1'b0;
      end else begin
        if (acc_s) begin
          rq.push_back(acc_a);
          acc_cnt++;
        end
        if (rq.size() > max_q) max_q = rq.size();
        if (resp_en && rq.size() != 0) begin
          bus.inst_sram_data_ok = 1'b1;
          bus.inst_sram_rdata   = mem(rq.pop_front());
        end else begin
          bus.inst_sram_data_ok = 1'b0;
        end
      end
    end
  end

  // monitor: every decode pop is checked against the queue
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!reset && bus.fs_to_ds_valid && bus.ds_allowin) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%h required=none",
                   bus.fs_to_ds_bus);
        end else begin
          e = exp_q.pop_front();
          chk("ds_out", bus.fs_to_ds_bus, e);
        end
      end
    end
  end

  initial begin
    int s;
    reset = 1'b1;
    bus.ds_allowin    = 1'b0;
    bus.br_bus        = '0;
    bus.fs_flush_pipe = 1'b0;
    bus.ws_to_fs_bus  = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req", 65'(bus.inst_sram_req), 65'(0));
    chk("rst_valid", 65'(bus.fs_to_ds_valid), 65'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("req_after_rst", 65'(bus.inst_sram_req), 65'(1));
    chk("addr_after_rst", 65'(bus.inst_sram_addr),
        65'(32'h1c000000));

    // 1: straight-line fetch
    tick();
    bus.ds_allowin = 1'b1;
    resp_en = 1'b1;
    expect_pc(32'h1c000000);
    expect_pc(32'h1c000004);
    expect_pc(32'h1c000008);
    grant_lim = acc_cnt + 3;
    drain("t1");

    // 2: decode stalled, IBUF fills, credit stops requests
    bus.ds_allowin = 1'b0;
    for (int i = 0; i < 6; i++)
      expect_pc(32'h1c00000c + 32'(4 * i));
    s = acc_cnt;
    grant_lim = acc_cnt + 6;
    repeat (10) tick();
    @(negedge clk);
    chk("full_req_low", 65'(bus.inst_sram_req), 65'(0));
    chk("full_valid", 65'(bus.fs_to_ds_valid), 65'(1));
    chk("full_accepts", 65'(acc_cnt - s), 65'(4));
    tick();
    bus.ds_allowin = 1'b1;
    drain("t2");

    // 3: redirect with two requests outstanding
    resp_en = 1'b0;
    grant_lim = acc_cnt + 2;
    repeat (4) tick();
    bus.br_bus = {1'b0, 1'b1, 32'h1c000100};
    tick();
    bus.br_bus = '0;
    expect_pc(32'h1c000100);
    grant_lim = acc_cnt + 1;
    resp_en = 1'b1;
    drain("t3");

    // 4: flush beats branch in the same cycle
    bus.fs_flush_pipe = 1'b1;
    bus.ws_to_fs_bus  = 32'h1c008000;
    bus.br_bus = {1'b0, 1'b1, 32'h1c000200};
    tick();
    bus.fs_flush_pipe = 1'b0;
    bus.br_bus = '0;
    expect_pc(32'h1c008000);
    grant_lim = acc_cnt + 1;
    drain("t4");

    // 5: redirect coincides with data_ok and addr_ok
    resp_en = 1'b0;
    grant_lim = acc_cnt + 2;
    repeat (4) tick();
    resp_en = 1'b1;
    tick();
    bus.br_bus = {1'b0, 1'b1, 32'h1c000300};
    grant_lim = acc_cnt + 1;
    tick();
    bus.br_bus = '0;
    expect_pc(32'h1c000300);
    drain("t5");

    // br_stall blocks new requests only
    bus.br_bus = {1'b1, 1'b0, 32'h0};
    grant_lim = acc_cnt + 1;
    tick();
    tick();
    @(negedge clk);
    chk("stall_req", 65'(bus.inst_sram_req), 65'(0));
    tick();
    bus.br_bus = '0;
    expect_pc(32'h1c000304);
    drain("stall");

`ifdef IF_ADEF_CHECK_EN
    // 6: misaligned target raises one ADEF entry
    bus.br_bus = {1'b0, 1'b1, 32'h1c000102};
    tick();
    bus.br_bus = '0;
    exp_q.push_back({1'b1, 32'h0, 32'h1c000102});
    @(negedge clk);
    chk("adef_req", 65'(bus.inst_sram_req), 65'(0));
    drain("t6");
    s = acc_cnt;
    grant_lim = acc_cnt + 1;
    repeat (6) tick();
    @(negedge clk);
    chk("adef_hold_req", 65'(bus.inst_sram_req), 65'(0));
    chk("adef_hold_acc", 65'(acc_cnt - s), 65'(0));
    tick();
    bus.fs_flush_pipe = 1'b1;
    bus.ws_to_fs_bus  = 32'h1c000400;
    tick();
    bus.fs_flush_pipe = 1'b0;
    expect_pc(32'h1c000400);
    drain("t6b");
`else
    // misaligned target: address is word-aligned on the bus
    bus.br_bus = {1'b0, 1'b1, 32'h1c000102};
    tick();
    bus.br_bus = '0;
    @(negedge clk);
    chk("align_addr", 65'(bus.inst_sram_addr),
        65'(32'h1c000100));
    chk("align_req", 65'(bus.inst_sram_req), 65'(1));
    tick();
    exp_q.push_back({1'b0, mem(32'h1c000100), 32'h1c000102});
    grant_lim = acc_cnt + 1;
    drain("align");
`endif

    repeat (5) tick();
    chk("sb_empty", 65'(exp_q.size()), 65'(0));
    chk("inflight_max", 65'(max_q), 65'(2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
